// File: rtl/wave_if.sv
// wave_if: control and sample bundle between the modulation source
// (wave_gen) and its host / consumer.
interface wave_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     low_in;
  logic [WIDTH-1:0]     high_in;
  logic [WIDTH-1:0]     step_in;
  logic [DIV_WIDTH-1:0] div_in;
  logic [WIDTH-1:0]     mod_out;
  logic                 dir_out;
  logic                 period_pulse;

  modport master (
    output enable, mode, low_in, high_in, step_in, div_in,
    input  mod_out, dir_out, period_pulse
  );

  modport slave (
    input  enable, mode, low_in, high_in, step_in, div_in,
    output mod_out, dir_out, period_pulse
  );
endinterface

// File: rtl/wave_gen.sv
// wave_gen: triangle / saw up / saw down / square generator with
// programmable clamped bounds, step size and tick prescaler.
module wave_gen #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  wave_if.slave bus
);
  typedef enum logic [1:0] {M_TRI, M_UP, M_DN, M_SQ} mode_t;
  typedef logic [WIDTH-1:0] smp_t;

  function automatic smp_t sat_up(smp_t b, smp_t s, smp_t lim);
    logic [WIDTH:0] r;
    r = {1'b0, b} + {1'b0, s};
    return (r >= {1'b0, lim}) ? lim : r[WIDTH-1:0];
  endfunction

  function automatic smp_t sat_dn(smp_t b, smp_t s, smp_t lim);
    logic [WIDTH:0] r;
    r = {1'b0, b} - {1'b0, s};
    return (r[WIDTH] || r[WIDTH-1:0] <= lim) ? lim : r[WIDTH-1:0];
  endfunction

  function automatic smp_t eff(smp_t s);
    return (s == '0) ? smp_t'(1) : s;
  endfunction

  smp_t                 cnt_q, cnt_d;
  smp_t                 lo_q, lo_d;
  smp_t                 hi_q, hi_d;
  smp_t                 stp_q, stp_d;
  mode_t                mode_q, mode_d;
  logic                 dir_q, dir_d;
  logic                 pulse_q, pulse_d;
  logic                 run_q, run_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;

  logic  tick;
  logic  rs;
  logic  rs_bump;
  smp_t  rs_lo;
  smp_t  stp_e;
  mode_t mode_in;

  assign tick    = (presc_q == bus.div_in);
  assign stp_e   = eff(stp_q);
  assign mode_in = mode_t'(bus.mode);

  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    stp_d   = stp_q;
    mode_d  = mode_q;
    run_d   = run_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    rs      = 1'b0;
    rs_bump = 1'b0;
    rs_lo   = lo_q;
    if (!bus.enable) begin
      presc_d = '0;
      run_d   = 1'b0;
    end else if (!run_q) begin
      run_d   = 1'b1;
      presc_d = '0;
      rs      = 1'b1;
      rs_lo   = bus.low_in;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (lo_q >= hi_q) begin
          // degenerate bounds: keep polling inputs, leave via low point
          rs      = 1'b1;
          rs_lo   = bus.low_in;
          rs_bump = 1'b1;
        end else begin
          unique case (mode_q)
            M_TRI: begin
              if (!dir_q) begin
                if (cnt_q == hi_q) begin
                  dir_d = 1'b1;
                  lo_d  = bus.low_in;
                  cnt_d = sat_dn(hi_q, stp_e, bus.low_in);
                end else begin
                  cnt_d = sat_up(cnt_q, stp_e, hi_q);
                end
              end else if (cnt_q == lo_q) begin
                rs      = 1'b1;
                rs_bump = 1'b1;
              end else begin
                cnt_d = sat_dn(cnt_q, stp_e, lo_q);
              end
            end
            M_UP: begin
              if (cnt_q == hi_q) begin
                rs    = 1'b1;
                rs_lo = bus.low_in;
              end else begin
                cnt_d = sat_up(cnt_q, stp_e, hi_q);
              end
            end
            M_DN: begin
              if (cnt_q == lo_q) begin
                rs    = 1'b1;
                rs_lo = bus.low_in;
              end else begin
                cnt_d = sat_dn(cnt_q, stp_e, lo_q);
              end
            end
            M_SQ: begin
              if (dir_q) begin
                rs    = 1'b1;
                rs_lo = bus.low_in;
              end else begin
                cnt_d = hi_q;
                dir_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
    // period start: relatch, then enter the new mode from rs_lo
    if (rs) begin
      lo_d   = rs_lo;
      hi_d   = bus.high_in;
      stp_d  = bus.step_in;
      mode_d = mode_in;
      if (rs_lo >= bus.high_in) begin
        cnt_d = rs_lo;
        dir_d = 1'b0;
      end else begin
        pulse_d = 1'b1;
        if (mode_in == M_DN || (rs_bump && mode_in == M_SQ)) begin
          cnt_d = bus.high_in;
          dir_d = 1'b1;
        end else if (rs_bump) begin
          cnt_d = sat_up(rs_lo, eff(bus.step_in), bus.high_in);
          dir_d = 1'b0;
        end else begin
          cnt_d = rs_lo;
          dir_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      stp_q   <= '0;
      mode_q  <= M_TRI;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      run_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      stp_q   <= stp_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      run_q   <= run_d;
      presc_q <= presc_d;
    end
  end

  assign bus.mod_out      = cnt_q;
  assign bus.dir_out      = dir_q;
  assign bus.period_pulse = pulse_q;
endmodule
